// File: rtl/dm_arbiter.sv
// Data-memory arbiter: M-stage CPU port vs external bus master.
// CPU has priority; starvation counter and lock state serve the external side.
module dm_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_re_M,
  input  logic        cpu_we_M,
  input  logic [31:0] cpu_addr_M,
  input  logic [31:0] cpu_wdata_M,
  input  logic [31:0] cpu_pc_M,
  output logic [31:0] cpu_rdata_M,
  output logic        stall_M,
  input  logic        ext_req,
  input  logic        ext_we,
  input  logic        ext_lock,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  output logic        ext_gnt,
  output logic [31:0] ext_rdata,
  output logic        ext_rvalid,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_rdata
);

  typedef enum logic {
    ST_SHARE = 1'b0,
    ST_LOCK  = 1'b1
  } st_t;

  st_t         r_st;
  st_t         w_st_nxt;
  logic [3:0]  r_wait_cnt;
  logic [3:0]  w_wait_nxt;
  logic [31:0] r_ext_rdata;
  logic        r_ext_rvalid;

  logic w_cpu_req;
  logic w_force;
  logic w_cpu_win;
  logic w_ext_win;

  assign w_cpu_req = cpu_re_M | cpu_we_M;
  assign w_force   = ext_req && (r_wait_cnt >= 4'(MAX_WAIT));

  // Winner select; nothing is granted while reset is held
  always_comb begin
    w_cpu_win = 1'b0;
    w_ext_win = 1'b0;
    if (!reset) begin
      unique case (r_st)
        ST_LOCK: w_ext_win = ext_req;
        default: begin
          if (w_force)
            w_ext_win = 1'b1;
          else if (w_cpu_req)
            w_cpu_win = 1'b1;
          else
            w_ext_win = ext_req;
        end
      endcase
    end
  end

  assign ext_gnt = w_ext_win;
  assign stall_M = w_cpu_req & ~w_cpu_win & ~reset;

  always_comb begin
    dm_we       = 1'b0;
    dm_addr     = '0;
    dm_wdata    = '0;
    dm_pc       = '0;
    cpu_rdata_M = '0;
    if (w_cpu_win) begin
      dm_we       = cpu_we_M;
      dm_addr     = cpu_addr_M;
      dm_wdata    = cpu_wdata_M;
      dm_pc       = cpu_pc_M;
      cpu_rdata_M = dm_rdata;
    end else if (w_ext_win) begin
      dm_we    = ext_we;
      dm_addr  = ext_addr;
      dm_wdata = ext_wdata;
    end
  end

  always_comb begin
    w_st_nxt = r_st;
    unique case (r_st)
      ST_SHARE:
        if (w_ext_win && ext_lock) w_st_nxt = ST_LOCK;
      ST_LOCK:
        if (!ext_req || !ext_lock) w_st_nxt = ST_SHARE;
      default: w_st_nxt = ST_SHARE;
    endcase
  end

  always_comb begin
    w_wait_nxt = '0;
    if (ext_req && !w_ext_win)
      w_wait_nxt = (r_wait_cnt == 4'hF) ? 4'hF : r_wait_cnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_st       <= ST_SHARE;
      r_wait_cnt <= '0;
    end else begin
      r_st       <= w_st_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  // External read data is registered; writes leave it untouched
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ext_rvalid <= 1'b0;
      r_ext_rdata  <= '0;
    end else begin
      r_ext_rvalid <= w_ext_win & ~ext_we;
      if (w_ext_win && !ext_we)
        r_ext_rdata <= dm_rdata;
    end
  end

  assign ext_rdata  = r_ext_rdata;
  assign ext_rvalid = r_ext_rvalid;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a simple word memory model.
// Table rows are consecutive clock cycles; a hand sequence covers wait reset.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_re_M, cpu_we_M;
  logic [31:0] cpu_addr_M, cpu_wdata_M, cpu_pc_M, cpu_rdata_M;
  logic        stall_M;
  logic        ext_req, ext_we, ext_lock;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;
  logic        ext_gnt, ext_rvalid;
  logic        dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_pc, dm_rdata;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_re_M(cpu_re_M), .cpu_we_M(cpu_we_M),
    .cpu_addr_M(cpu_addr_M), .cpu_wdata_M(cpu_wdata_M),
    .cpu_pc_M(cpu_pc_M), .cpu_rdata_M(cpu_rdata_M),
    .stall_M(stall_M),
    .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_pc(dm_pc), .dm_rdata(dm_rdata)
  );

  // Memory model: async read, write on rising edge
  logic [31:0] mem [0:1023];
  logic        mem_clr;
  assign dm_rdata = mem[dm_addr[11:2]];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
    end else if (dm_we) begin
      mem[dm_addr[11:2]] <= dm_wdata;
    end
  end

  typedef struct {
    logic        rst, cre, cwe;
    logic [31:0] caddr, cwd, cpc;
    logic        ereq, ewe, elk;
    logic [31:0] eaddr, ewd;
    logic        gnt, stall, dwe;
    logic [31:0] daddr, dwd, dpc, crd;
    logic        rv;
    logic [31:0] erd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(
    input logic rst, cre, cwe,
    input logic [31:0] caddr, cwd, cpc,
    input logic ereq, ewe, elk,
    input logic [31:0] eaddr, ewd,
    input logic gnt, stall, dwe,
    input logic [31:0] daddr, dwd, dpc, crd,
    input logic rv,
    input logic [31:0] erd);
    vec_t v;
    v.rst = rst; v.cre = cre; v.cwe = cwe;
    v.caddr = caddr; v.cwd = cwd; v.cpc = cpc;
    v.ereq = ereq; v.ewe = ewe; v.elk = elk;
    v.eaddr = eaddr; v.ewd = ewd;
    v.gnt = gnt; v.stall = stall; v.dwe = dwe;
    v.daddr = daddr; v.dwd = dwd; v.dpc = dpc; v.crd = crd;
    v.rv = rv; v.erd = erd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int row,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst;
    cpu_re_M = v.cre; cpu_we_M = v.cwe;
    cpu_addr_M = v.caddr; cpu_wdata_M = v.cwd; cpu_pc_M = v.cpc;
    ext_req = v.ereq; ext_we = v.ewe; ext_lock = v.elk;
    ext_addr = v.eaddr; ext_wdata = v.ewd;
  endtask

  task automatic set_cpu(input logic re, input logic [31:0] a,
                         input logic [31:0] pc);
    cpu_re_M = re; cpu_we_M = 1'b0;
    cpu_addr_M = a; cpu_wdata_M = '0; cpu_pc_M = pc;
  endtask

  task automatic set_ext(input logic req, input logic [31:0] a);
    ext_req = req; ext_we = 1'b0; ext_lock = 1'b0;
    ext_addr = a; ext_wdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int gnt_at;
    // idle / reset
    add(1,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0,0,0);
    for (int i = 0; i < 3; i++)
      add(0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0,0,0);
    // CPU store then load
    add(0,0,1,32'h10,32'h12345678,32'h3008, 0,0,0,0,0,
        0,0,1,32'h10,32'h12345678,32'h3008,0,0,0);
    add(0,1,0,32'h10,0,32'h300c, 0,0,0,0,0,
        0,0,0,32'h10,0,32'h300c,32'h12345678,0,0);
    add(0,0,1,32'h20,32'hA5A50020,32'h3010, 0,0,0,0,0,
        0,0,1,32'h20,32'hA5A50020,32'h3010,0,0,0);
    // contention: forced ext slot on the 5th refused cycle
    for (int i = 0; i < 4; i++)
      add(0,1,0,32'h10,0,32'h3014, 1,0,0,32'h20,0,
          0,0,0,32'h10,0,32'h3014,32'h12345678,0,0);
    add(0,1,0,32'h10,0,32'h3014, 1,0,0,32'h20,0,
        1,1,0,32'h20,0,0,0,0,0);
    add(0,1,0,32'h10,0,32'h3014, 0,0,0,0,0,
        0,0,0,32'h10,0,32'h3014,32'h12345678,1,32'hA5A50020);
    // locked burst, first beat forced through by the wait counter
    for (int i = 0; i < 4; i++)
      add(0,1,0,32'h10,0,32'h3018, 1,1,1,32'h40,32'h11111111,
          0,0,0,32'h10,0,32'h3018,32'h12345678,0,32'hA5A50020);
    add(0,1,0,32'h10,0,32'h3018, 1,1,1,32'h40,32'h11111111,
        1,1,1,32'h40,32'h11111111,0,0,0,32'hA5A50020);
    add(0,1,0,32'h10,0,32'h3018, 1,1,1,32'h44,32'h22222222,
        1,1,1,32'h44,32'h22222222,0,0,0,32'hA5A50020);
    add(0,1,0,32'h10,0,32'h3018, 1,1,0,32'h48,32'h33333333,
        1,1,1,32'h48,32'h33333333,0,0,0,32'hA5A50020);
    add(0,1,0,32'h44,0,32'h301c, 0,0,0,0,0,
        0,0,0,32'h44,0,32'h301c,32'h22222222,0,32'hA5A50020);
    add(0,1,0,32'h48,0,32'h3020, 0,0,0,0,0,
        0,0,0,32'h48,0,32'h3020,32'h33333333,0,32'hA5A50020);
    add(0,1,0,32'h40,0,32'h3024, 0,0,0,0,0,
        0,0,0,32'h40,0,32'h3024,32'h11111111,0,32'hA5A50020);
    // ext-only locked read of 0x0, then reset in the 2nd lock cycle
    add(0,0,0,0,0,0, 1,0,1,0,0,
        1,0,0,0,0,0,0,0,32'hA5A50020);
    add(1,1,0,32'h10,0,32'h3028, 1,0,1,32'h44,0,
        0,0,0,0,0,0,0,1,0);
    add(0,1,0,32'h10,0,32'h3028, 1,0,1,32'h44,0,
        0,0,0,32'h10,0,32'h3028,32'h12345678,0,0);
    // ext-only unlocked read: same-cycle grant, rvalid next cycle
    add(0,0,0,0,0,0, 1,0,0,32'h44,0,
        1,0,0,32'h44,0,0,0,0,0);
    add(0,0,0,0,0,0, 0,0,0,0,0,
        0,0,0,0,0,0,0,1,32'h22222222);
    add(0,0,0,0,0,0, 0,0,0,0,0,
        0,0,0,0,0,0,0,0,32'h22222222);
    // re and we together act as a store
    add(0,1,1,32'h50,32'hDEADBEEF,32'h4000, 0,0,0,0,0,
        0,0,1,32'h50,32'hDEADBEEF,32'h4000,0,0,32'h22222222);
    add(0,1,0,32'h50,0,32'h4004, 0,0,0,0,0,
        0,0,0,32'h50,0,32'h4004,32'hDEADBEEF,0,32'h22222222);

    mem_clr = 1'b1;
    drive(vecs[0]);
    next_cycle();
    mem_clr = 1'b0;

    foreach (vecs[r]) begin
      drive(vecs[r]);
      @(negedge clk);
      chk("ext_gnt",     r, 32'(ext_gnt),    32'(vecs[r].gnt));
      chk("stall_M",     r, 32'(stall_M),    32'(vecs[r].stall));
      chk("dm_we",       r, 32'(dm_we),      32'(vecs[r].dwe));
      chk("dm_addr",     r, dm_addr,         vecs[r].daddr);
      chk("dm_wdata",    r, dm_wdata,        vecs[r].dwd);
      chk("dm_pc",       r, dm_pc,           vecs[r].dpc);
      chk("cpu_rdata_M", r, cpu_rdata_M,     vecs[r].crd);
      chk("ext_rvalid",  r, 32'(ext_rvalid), 32'(vecs[r].rv));
      chk("ext_rdata",   r, ext_rdata,       vecs[r].erd);
      next_cycle();
    end

    // Dropping a refused request clears the wait count
    reset = 1'b0;
    set_cpu(1'b1, 32'h10, 32'h5000);
    set_ext(1'b1, 32'h48);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("seq_refused_gnt", 100 + i, 32'(ext_gnt), 32'd0);
      chk("seq_refused_stall", 100 + i, 32'(stall_M), 32'd0);
      next_cycle();
    end
    ext_req = 1'b0;
    @(negedge clk);
    chk("seq_drop_gnt", 103, 32'(ext_gnt), 32'd0);
    next_cycle();
    ext_req = 1'b1;
    gnt_at = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ext_gnt) begin
        gnt_at = i;
        chk("seq_forced_stall", 104, 32'(stall_M), 32'd1);
        next_cycle();
        break;
      end
      next_cycle();
    end
    chk("seq_grant_cycle", 105, 32'(gnt_at), 32'd4);
    ext_req = 1'b0;
    @(negedge clk);
    chk("seq_rvalid", 106, 32'(ext_rvalid), 32'd1);
    chk("seq_rdata", 107, ext_rdata, 32'h33333333);
    chk("seq_cpu_back", 108, cpu_rdata_M, 32'h12345678);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Single-port data-memory arbiter between the MIPS pipeline M stage and an external bus master (loader/debug/DMA port). Grants exactly one memory access per cycle. CPU has priority, but a starvation counter guarantees the external master a slot. A lock state gives the external master exclusive bursts. When the CPU loses arbitration it receives a stall, which freezes the pipeline at M.

## Interface

Parameters:
- MAX_WAIT, 4: cycles an external request may be refused before it is forced through; legal range 1..15.

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  synchronous, active-high
- cpu_re_M  in  1  M-stage load valid
- cpu_we_M  in  1  M-stage store valid (memwrite_M)
- cpu_addr_M  in  32  byte address (ALU result)
- cpu_wdata_M  in  32  store data
- cpu_pc_M  in  32  PC of M-stage instruction
- cpu_rdata_M  out  32  load data
- stall_M  out  1  CPU access refused this cycle
- ext_req  in  1  external access request
- ext_we  in  1  1 = write, 0 = read
- ext_lock  in  1  hold bus after this grant
- ext_addr  in  32  byte address
- ext_wdata  in  32  write data
- ext_gnt  out  1  external access performed this cycle
- ext_rdata  out  32  registered read data
- ext_rvalid  out  1  ext_rdata valid (one-cycle pulse)
- dm_we  out  1  memory write enable
- dm_addr  out  32  memory address (memory uses [11:2])
- dm_wdata  out  32  memory write data
- dm_pc  out  32  PC for the memory write trace; 0 on external writes
- dm_rdata  in  32  asynchronous memory read data

## Operation

- cpu_req = cpu_re_M | cpu_we_M.
- Registered state: st ∈ {ST_SHARE, ST_LOCK}; wait_cnt (4 bits, saturating at 15).
- Winner is decided combinationally each cycle:
  - ST_LOCK: ext wins whenever ext_req. CPU never wins.
  - ST_SHARE, ext_req and wait_cnt ≥ MAX_WAIT: ext wins.
  - ST_SHARE otherwise: CPU wins if cpu_req; else ext wins if ext_req.
- ext_gnt = ext wins.
- stall_M = cpu_req & ~(CPU wins).
- Memory mux:
  - CPU wins: dm_we = cpu_we_M, dm_addr = cpu_addr_M, dm_wdata = cpu_wdata_M, dm_pc = cpu_pc_M.
  - ext wins: dm_we = ext_we, dm_addr = ext_addr, dm_wdata = ext_wdata, dm_pc = 0.
  - No winner: dm_we = 0, dm_addr = 0, dm_wdata = 0, dm_pc = 0.
- cpu_rdata_M = dm_rdata when CPU wins, else 0.
- wait_cnt next value:
  - 0 if ext_gnt or ~ext_req.
  - Otherwise wait_cnt+1, saturating at 15.
- st next value:
  - ST_SHARE → ST_LOCK when ext_gnt & ext_lock.
  - ST_LOCK → ST_SHARE when ~ext_req or ~ext_lock. A granted access in the release cycle still completes.
  - Otherwise hold.
- ext read: when ext_gnt & ~ext_we, ext_rdata ← dm_rdata and ext_rvalid ← 1 at the next edge. Otherwise ext_rvalid ← 0 and ext_rdata holds.
- An external write only touches memory. It leaves ext_rdata unchanged.
- cpu_re_M and cpu_we_M both high is treated as a store.

## Timing

- Reset (synchronous) sets st = ST_SHARE, wait_cnt = 0, ext_rvalid = 0, ext_rdata = 0.
- Combinational outputs during reset: ext_gnt = 0, stall_M = 0, dm_we = 0, dm_addr = 0, dm_wdata = 0, dm_pc = 0, cpu_rdata_M = 0. Memory is cleared by its own reset.
- CPU access latency is 0: load data and store commit happen in the grant cycle.
- ext write commits at the grant edge. ext read data appears 1 cycle after grant.
- The external master holds ext_req, ext_we, ext_addr and ext_wdata stable until ext_gnt. It may drop ext_req in the cycle after a grant.
- A CPU request stalls for at most 1 cycle per forced ext slot. In ST_LOCK it stalls for the whole lock duration.
- Reset asserted mid-lock returns st to ST_SHARE and cancels any pending ext_rvalid. It does not write memory in that cycle.
- ext_req dropping while refused clears wait_cnt. No grant is issued.

## Test plan

- Reset then idle: after 1 cycle of reset, every output is 0 and st = ST_SHARE. Check again after 3 further idle cycles.
- CPU store/load only:
  - sw of 0x12345678 to 0x10 at pc 0x3008 drives dm_we = 1, dm_addr = 0x10, dm_pc = 0x3008, stall_M = 0.
  - The next cycle's lw from 0x10 returns 0x12345678 on cpu_rdata_M.
- Contention, MAX_WAIT = 4: cpu_req held high and ext read of 0x20 held high.
  - Cycles 0–3: CPU wins and ext_gnt = 0.
  - Cycle 4: ext_gnt = 1 and stall_M = 1.
  - Cycle 5: ext_rvalid = 1 with the contents of 0x20; CPU wins again.
- Locked burst: ext writes 0x40, 0x44, 0x48 with ext_lock = 1, ext_lock = 0 on the last, cpu_req high throughout.
  - Three consecutive ext_gnt cycles, with stall_M = 1 in all three.
  - CPU granted in the 4th cycle.
- Reset mid-lock: assert reset in the 2nd cycle of a locked burst.
  - That cycle: dm_we = 0 and ext_gnt = 0.
  - Next cycle: st = ST_SHARE and ext_rvalid = 0.
- ext-only with no CPU request: ext_req for an ext read of 0x0 is granted in the same cycle, and ext_rvalid pulses the next cycle.
